// File: rtl/ctrl_pkg.sv
// Shared definitions for the bus-computer microcode sequencer: opcodes,
// step encoding, sequencer states and the control word in bus order.
package ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] STEP_T0   = 3'd0;
  localparam logic [2:0] STEP_T1   = 3'd1;
  localparam logic [2:0] STEP_T2   = 3'd2;
  localparam logic [2:0] STEP_T3   = 3'd3;
  localparam logic [2:0] STEP_T4   = 3'd4;
  localparam logic [2:0] STEP_T5   = 3'd5;
  localparam logic [2:0] STEP_IDLE = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  // Field order matches the enable order on the shared bus, MSB first.
  typedef struct packed {
    logic pcoe;
    logic pcjmp;
    logic pcinc;
    logic awa;
    logic aoa;
    logic bwa;
    logic boa;
    logic sumout;
    logic sub;
    logic flagsin;
    logic marwa;
    logic ramoa;
    logic ramwa;
    logic inregwa;
    logic inregoa;
    logic outregwa;
  } ctrl_word_t;

  localparam ctrl_word_t CW_NONE = '0;

  // Instructions whose T2 puts the operand address into the MAR.
  function automatic logic loads_mar(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
  endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// Combinational microcode ROM: control word, final-step and halt flags for
// the step about to be entered.
module ctrl_seq_decode
  import ctrl_pkg::*;
(
  input  logic [2:0]  i_step,
  input  logic [3:0]  i_opcode,
  input  logic        i_cf,
  input  logic        i_zf,
  output ctrl_word_t  o_ctrl,
  output logic        o_last,
  output logic        o_halt
);

  ctrl_word_t w_cw;
  logic       w_last;
  logic       w_halt;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_cw   = CW_NONE;
    w_last = 1'b0;
    w_halt = 1'b0;
    case (i_step)
      STEP_T0: begin
        w_cw.pcoe  = 1'b1;
        w_cw.marwa = 1'b1;
      end
      STEP_T1: begin
        w_cw.ramoa   = 1'b1;
        w_cw.inregwa = 1'b1;
        w_cw.pcinc   = 1'b1;
      end
      STEP_T2: begin
        if (loads_mar(i_opcode)) begin
          w_cw.inregoa = 1'b1;
          w_cw.marwa   = 1'b1;
        end else begin
          w_last = 1'b1;
          case (i_opcode)
            OP_JMP: begin
              w_cw.inregoa = 1'b1;
              w_cw.pcjmp   = 1'b1;
            end
            OP_JC: begin
              w_cw.inregoa = 1'b1;
              w_cw.pcjmp   = i_cf;
            end
            OP_JZ: begin
              w_cw.inregoa = 1'b1;
              w_cw.pcjmp   = i_zf;
            end
            OP_OUT: begin
              w_cw.aoa      = 1'b1;
              w_cw.outregwa = 1'b1;
            end
            OP_HLT:  w_halt = 1'b1;
            default: w_cw   = CW_NONE;
          endcase
        end
      end
      STEP_T3: begin
        case (i_opcode)
          OP_LDA: begin
            w_cw.ramoa = 1'b1;
            w_cw.awa   = 1'b1;
            w_last     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            w_cw.ramoa = 1'b1;
            w_cw.bwa   = 1'b1;
          end
          OP_STA: begin
            w_cw.aoa   = 1'b1;
            w_cw.ramwa = 1'b1;
            w_last     = 1'b1;
          end
          default: w_last = 1'b1;
        endcase
      end
      STEP_T4: begin
        w_last = 1'b1;
        if ((i_opcode == OP_ADD) || (i_opcode == OP_SUB)) begin
          w_cw.sumout  = 1'b1;
          w_cw.awa     = 1'b1;
          w_cw.flagsin = 1'b1;
          w_cw.sub     = (i_opcode == OP_SUB);
        end
      end
      // T5 and the IDLE code are dead ends: drive nothing, return to T0.
      default: w_last = 1'b1;
    endcase
  end

  assign o_ctrl = w_cw;
  assign o_last = w_last;
  assign o_halt = w_halt;

endmodule

// File: rtl/ctrl_seq.sv
// Microcode sequencer top: step/halt state, opcode latch and the registered
// control word, all updated on the falling clock edge.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int NSTEP = 6
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       cf,
  input  logic       zf,
  output logic       pcoe,
  output logic       pcjmp,
  output logic       pcinc,
  output logic       awa,
  output logic       aoa,
  output logic       bwa,
  output logic       boa,
  output logic       sumout,
  output logic       sub,
  output logic       flagsin,
  output logic       marwa,
  output logic       ramoa,
  output logic       ramwa,
  output logic       inregwa,
  output logic       inregoa,
  output logic       outregwa,
  output logic       halt,
  output logic [2:0] step
);

  localparam logic [2:0] LAST_RING_STEP = 3'(NSTEP - 1);

  seq_state_t r_state;
  seq_state_t w_state_next;
  logic [2:0] r_step;
  logic [2:0] w_step_next;
  logic [3:0] r_opcode;
  logic       r_last;
  logic       r_halt;
  ctrl_word_t r_ctrl;

  logic [2:0] w_dec_step;
  logic [3:0] w_dec_opcode;
  ctrl_word_t w_dec_ctrl;
  logic       w_dec_last;
  logic       w_dec_halt;

  ctrl_word_t w_ctrl_next;
  logic       w_last_next;
  logic       w_halt_next;

  ctrl_seq_decode u_decode (
    .i_step   (w_dec_step),
    .i_opcode (w_dec_opcode),
    .i_cf     (cf),
    .i_zf     (zf),
    .o_ctrl   (w_dec_ctrl),
    .o_last   (w_dec_last),
    .o_halt   (w_dec_halt)
  );

  // State register: falling edge so the control word is settled for the
  // datapath's rising-edge latch.
  always_ff @(negedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!clr) begin
      r_state  <= ST_IDLE;
      r_step   <= STEP_IDLE;
      r_opcode <= OP_NOP;
      r_last   <= 1'b0;
      r_halt   <= 1'b0;
      r_ctrl   <= CW_NONE;
    end else begin
      r_state  <= w_state_next;
      r_step   <= w_step_next;
      r_opcode <= w_dec_opcode;
      r_last   <= w_last_next;
      r_halt   <= w_halt_next;
      r_ctrl   <= w_ctrl_next;
    end
  end

  // Next state: the step to enter, and the opcode it decodes against.
  always_comb begin
    w_dec_step   = STEP_T0;
    w_state_next = r_state;
    w_step_next  = r_step;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_RUN;
        w_step_next  = STEP_T0;
      end
      ST_RUN: begin
        if (r_last || (r_step >= LAST_RING_STEP)) begin
          w_dec_step = STEP_T0;
        end else begin
          w_dec_step = r_step + 3'd1;
        end
        if (w_dec_halt) begin
          w_state_next = ST_HALT;
          w_step_next  = STEP_IDLE;
        end else begin
          w_step_next = w_dec_step;
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
        w_step_next  = STEP_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_step_next  = STEP_IDLE;
      end
    endcase
    if (!clr) begin
      w_state_next = ST_IDLE;
      w_step_next  = STEP_IDLE;
    end
  end

  // The opcode is captured only on the edge entering T2; later steps of the
  // same instruction decode against the latched copy.
  assign w_dec_opcode = (r_state == ST_RUN && w_dec_step == STEP_T2) ? opcode : r_opcode;

  // Outputs for the state being entered.
  always_comb begin
    w_ctrl_next = CW_NONE;
    w_last_next = 1'b0;
    w_halt_next = 1'b0;
    case (w_state_next)
      ST_RUN: begin
        w_ctrl_next = w_dec_ctrl;
        w_last_next = w_dec_last;
      end
      ST_HALT: w_halt_next = 1'b1;
      default: w_ctrl_next = CW_NONE;
    endcase
  end

  assign pcoe     = r_ctrl.pcoe;
  assign pcjmp    = r_ctrl.pcjmp;
  assign pcinc    = r_ctrl.pcinc;
  assign awa      = r_ctrl.awa;
  assign aoa      = r_ctrl.aoa;
  assign bwa      = r_ctrl.bwa;
  assign boa      = r_ctrl.boa;
  assign sumout   = r_ctrl.sumout;
  assign sub      = r_ctrl.sub;
  assign flagsin  = r_ctrl.flagsin;
  assign marwa    = r_ctrl.marwa;
  assign ramoa    = r_ctrl.ramoa;
  assign ramwa    = r_ctrl.ramwa;
  assign inregwa  = r_ctrl.inregwa;
  assign inregoa  = r_ctrl.inregoa;
  assign outregwa = r_ctrl.outregwa;
  assign halt     = r_halt;
  assign step     = r_step;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed scenarios with literal
// expectations plus randomized traffic against an instruction-level model.
module tb_ctrl_seq;
  import ctrl_pkg::*;

  localparam logic [15:0] M_PCOE     = 16'h8000;
  localparam logic [15:0] M_PCJMP    = 16'h4000;
  localparam logic [15:0] M_PCINC    = 16'h2000;
  localparam logic [15:0] M_AWA      = 16'h1000;
  localparam logic [15:0] M_AOA      = 16'h0800;
  localparam logic [15:0] M_BWA      = 16'h0400;
  localparam logic [15:0] M_BOA      = 16'h0200;
  localparam logic [15:0] M_SUMOUT   = 16'h0100;
  localparam logic [15:0] M_SUB      = 16'h0080;
  localparam logic [15:0] M_FLAGSIN  = 16'h0040;
  localparam logic [15:0] M_MARWA    = 16'h0020;
  localparam logic [15:0] M_RAMOA    = 16'h0010;
  localparam logic [15:0] M_RAMWA    = 16'h0008;
  localparam logic [15:0] M_INREGWA  = 16'h0004;
  localparam logic [15:0] M_INREGOA  = 16'h0002;
  localparam logic [15:0] M_OUTREGWA = 16'h0001;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       cf = 1'b0;
  logic       zf = 1'b0;
  logic pcoe, pcjmp, pcinc, awa, aoa, bwa, boa, sumout, sub, flagsin;
  logic marwa, ramoa, ramwa, inregwa, inregoa, outregwa, halt;
  logic [2:0] step;
  logic [15:0] dut_word;
  int unsigned n_drivers;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ctrl_seq #(.NSTEP(6)) dut (
    .clk(clk), .clr(clr), .opcode(opcode), .cf(cf), .zf(zf),
    .pcoe(pcoe), .pcjmp(pcjmp), .pcinc(pcinc), .awa(awa), .aoa(aoa),
    .bwa(bwa), .boa(boa), .sumout(sumout), .sub(sub), .flagsin(flagsin),
    .marwa(marwa), .ramoa(ramoa), .ramwa(ramwa), .inregwa(inregwa),
    .inregoa(inregoa), .outregwa(outregwa), .halt(halt), .step(step)
  );

  assign dut_word = {pcoe, pcjmp, pcinc, awa, aoa, bwa, boa, sumout, sub, flagsin,
                     marwa, ramoa, ramwa, inregwa, inregoa, outregwa};
  assign n_drivers = 32'(pcoe) + 32'(aoa) + 32'(boa) + 32'(sumout) + 32'(ramoa) + 32'(inregoa);

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic int norm_op(input logic [3:0] op);
    case (op)
      OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: return int'(op);
      default: return int'(OP_NOP);
    endcase
  endfunction

  function automatic int instr_len(input int op);
    case (op)
      1, 4:    return 4;
      2, 3:    return 5;
      default: return 3;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input int t, input int op, input bit c, input bit z);
    if (t == 0) return M_PCOE | M_MARWA;
    if (t == 1) return M_RAMOA | M_INREGWA | M_PCINC;
    case (op)
      1: return (t == 2) ? (M_INREGOA | M_MARWA) : (M_RAMOA | M_AWA);
      2, 3: begin
        if (t == 2) return M_INREGOA | M_MARWA;
        if (t == 3) return M_RAMOA | M_BWA;
        return M_SUMOUT | M_AWA | M_FLAGSIN | ((op == 3) ? M_SUB : 16'h0);
      end
      4:  return (t == 2) ? (M_INREGOA | M_MARWA) : (M_AOA | M_RAMWA);
      6:  return M_INREGOA | M_PCJMP;
      7:  return M_INREGOA | (c ? M_PCJMP : 16'h0);
      8:  return M_INREGOA | (z ? M_PCJMP : 16'h0);
      14: return M_AOA | M_OUTREGWA;
      default: return 16'h0;
    endcase
  endfunction

  int m_mode  = M_IDLE;
  int m_t     = 0;
  int m_op    = 0;
  bit m_cf    = 1'b0;
  bit m_zf    = 1'b0;
  bit m_valid = 1'b0;

  always @(negedge clk) begin
    if (!clr) begin
      m_mode  = M_IDLE;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_mode)
        M_IDLE: begin
          m_mode = M_RUN;
          m_t    = 0;
        end
        M_HALT: m_mode = M_HALT;
        default: begin
          if (m_t == 1) begin
            m_op = norm_op(opcode);
            m_cf = cf;
            m_zf = zf;
            if (m_op == 15) m_mode = M_HALT;
            else m_t = 2;
          end else if (m_t >= 2 && m_t + 1 >= instr_len(m_op)) begin
            m_t = 0;
          end else begin
            m_t = m_t + 1;
          end
        end
      endcase
    end
  end

  // Compare process: outputs are stable across the rising edge.
  always @(posedge clk) begin
    if (m_valid) begin
      check("word", 32'(dut_word),
            (m_mode == M_RUN) ? 32'(exp_word(m_t, m_op, m_cf, m_zf)) : 32'h0);
      if (m_mode != M_HALT)
        check("step", 32'(step), (m_mode == M_RUN) ? m_t : 7);
      check("halt", 32'(halt), (m_mode == M_HALT) ? 32'd1 : 32'd0);
      check("bus_excl", (n_drivers <= 1) ? 32'd1 : 32'd0, 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_step(input logic [2:0] target, input string name);
    int k = 0;
    while (step !== target && k < 20) begin
      tick();
      k++;
    end
    check(name, 32'(step), 32'(target));
  endtask

  // Called while sitting in T0; returns the clocks until the next T0.
  task automatic measure(output int n, output logic [15:0] words [8]);
    for (int i = 0; i < 8; i++) words[i] = 16'h0;
    words[0] = dut_word;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (step == STEP_T0) break;
      if (n < 8) words[n] = dut_word;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [15:0] w [8];
    int halt_run;

    clr = 1'b0;
    repeat (3) tick();
    check("reset_step", 32'(step), 32'd7);
    check("reset_word", 32'(dut_word), 32'h0);
    check("reset_halt", 32'(halt), 32'h0);

    clr = 1'b1;
    opcode = OP_LDA;
    tick();
    check("release_step", 32'(step), 32'd0);
    check("release_word", 32'(dut_word), 32'(M_PCOE | M_MARWA));

    measure(n, w);
    check("lda_len", n, 4);
    check("lda_t1", 32'(w[1]), 32'(M_RAMOA | M_INREGWA | M_PCINC));
    check("lda_t2", 32'(w[2]), 32'(M_INREGOA | M_MARWA));
    check("lda_t3", 32'(w[3]), 32'(M_RAMOA | M_AWA));

    opcode = OP_SUB;
    measure(n, w);
    check("sub_len", n, 5);
    check("sub_t4", 32'(w[4]), 32'(M_SUMOUT | M_AWA | M_FLAGSIN | M_SUB));

    opcode = OP_JC;
    cf = 1'b1;
    measure(n, w);
    check("jc1_len", n, 3);
    check("jc1_t2", 32'(w[2]), 32'(M_INREGOA | M_PCJMP));
    cf = 1'b0;
    measure(n, w);
    check("jc0_len", n, 3);
    check("jc0_t2", 32'(w[2]), 32'(M_INREGOA));

    cf = 1'b1;
    wait_step(STEP_T2, "jc_toggle_reach_t2");
    cf = 1'b0;
    #2;
    check("jc_toggle_pcjmp", 32'(pcjmp), 32'd1);
    wait_step(STEP_T0, "jc_toggle_back_t0");

    opcode = OP_HLT;
    tick();
    tick();
    check("hlt_after_t1", 32'(halt), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hlt_hold_word", 32'(dut_word), 32'h0);
    end
    clr = 1'b0;
    tick();
    check("hlt_reset_step", 32'(step), 32'd7);
    check("hlt_reset_halt", 32'(halt), 32'd0);

    clr = 1'b1;
    opcode = OP_ADD;
    tick();
    wait_step(STEP_T3, "add_reach_t3");
    clr = 1'b0;
    tick();
    check("midreset_word", 32'(dut_word), 32'h0);
    check("midreset_step", 32'(step), 32'd7);
    clr = 1'b1;
    tick();
    check("restart_step", 32'(step), 32'd0);
    check("restart_word", 32'(dut_word), 32'(M_PCOE | M_MARWA));

    halt_run = 0;
    for (int i = 0; i < 3000; i++) begin
      opcode = 4'($urandom_range(0, 15));
      cf     = 1'($urandom_range(0, 1));
      zf     = 1'($urandom_range(0, 1));
      halt_run = (m_mode == M_HALT) ? halt_run + 1 : 0;
      clr = (halt_run >= 4) ? 1'b0 : ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
